// File: rtl/stream_muxn_rr_if.sv
// Valid/ready bundle between NCH producers, the N:1 mux and its single consumer.
// master = producer/consumer side, slave = mux side.
interface stream_muxn_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_ch;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_muxn_rr.sv
// Registered N:1 valid/ready mux, manual select or round-robin; optional STREAM_MUXN_CNT_EN adds xfer_cnt.
// Latency: 1 cycle input transfer -> out_valid; 1 word/cycle sustained while out_ready=1.
// Backpressure: in_ready only when the output register is empty or draining (out_ready -> in_ready comb).
module stream_muxn_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_muxn_rr_if.slave     bus
`ifdef STREAM_MUXN_CNT_EN
    ,
    output logic [15:0]         xfer_cnt
`endif
);
    localparam int SELW = $clog2(NCH);
    localparam int CW   = SELW + 1;
    localparam logic [CW-1:0] NCH_W = CW'(NCH);

    logic [WIDTH-1:0] ch_data [NCH];
    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  grant;
    logic             grant_vld;
    logic [CW-1:0]    cand;
    logic             load;
    logic             xfer;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign load = !bus.out_valid || bus.out_ready;

    // RR search starts one past the last granted channel, wrapping modulo NCH.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        if (!bus.mode) begin
            if ({1'b0, bus.sel} < NCH_W && bus.in_valid[bus.sel]) begin
                grant     = bus.sel;
                grant_vld = 1'b1;
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                cand = {1'b0, rr_ptr} + CW'(k);
                if (cand >= NCH_W) begin
                    cand = cand - NCH_W;
                end
                if (!grant_vld && bus.in_valid[cand[SELW-1:0]]) begin
                    grant     = cand[SELW-1:0];
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.in_ready[i] = load && grant_vld && (grant == SELW'(i));
        end
    end

    assign xfer = load && grant_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            rr_ptr        <= SELW'(NCH - 1);
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= ch_data[grant];
            bus.out_ch    <= grant;
            if (bus.mode) begin
                rr_ptr <= grant;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUXN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (xfer && xfer_cnt != 16'hFFFF) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/stream_muxn_rr.md
Name: stream_muxn_rr

Overview:
- Parametrised, registered N:1 multiplexer for valid/ready streams; the successor to the fixed 8-bit 4:1 combinational mux.
- Each cycle selects one of NCH input channels, either by an explicit select (manual mode) or by round-robin arbitration (RR mode).
- Forwards the chosen word through a single output register with backpressure.
- Sits between multiple producers and one shared consumer, e.g. a display, UART or memory port.

Parameters:
- WIDTH, 8, data width of every channel and of the output.
- NCH, 4, number of input channels, 2..16.
- SELW, $clog2(NCH), width of sel and out_ch; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = manual select via sel; 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NCH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; at most one bit high.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1, so channel 0 has first RR priority.
- load = !out_valid || out_ready. The output register can accept a new word in the same cycle its current word leaves.
- Grant, combinational, only evaluated when load=1:
  - mode=0: grant = sel if sel<NCH and in_valid[sel]=1; otherwise no grant.
  - mode=1: grant = first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NCH. Wrap-around: after NCH-1 comes 0.
  - No in_valid set: no grant.
- in_ready[i] = load && grant valid && grant==i. All in_ready bits are 0 when load=0.
- Transfer on input i: in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - rr_ptr <= i (RR mode only; in manual mode rr_ptr holds its value).
- Output handshake:
  - out_valid && out_ready with no new transfer: out_valid <= 0; out_data and out_ch hold.
  - out_valid && !out_ready: all outputs hold; no input transfer occurs.
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle while out_ready=1.
- Fairness: in RR mode with all channels valid, grants cycle 0,1,...,NCH-1,0. A channel waits at most NCH-1 transfers.
- Mode or sel change: takes effect at the next arbitration. A word already in the output register is never lost or duplicated.
- Reset mid-operation: the pending output word is discarded and outputs return to their reset values immediately.
- No combinational path from in_valid to out_valid. The path out_ready -> in_ready is combinational and permitted.

Optional Feature:
- Macro: STREAM_MUXN_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0], the count of input transfers since reset.
  - Increments by 1 per transfer and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; first RR grant after release goes to channel 0.
- Manual select: mode=0, sel=2, ch2 data=8'hC3 valid, ch0 also valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hC3, out_ch=2; ch0 is never granted.
- Round-robin fairness: mode=1, all four valid with data 8'h10..8'h13, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and out_data matches each channel.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data/out_ch stable; raise out_ready -> the next word loads in the same cycle the old word leaves, with no bubble.
- RR wrap and sparse: rr_ptr=3, only ch1 and ch3 valid -> grant ch1, then ch3, then ch1.
- Counter (STREAM_MUXN_CNT_EN defined): 70000 back-to-back transfers -> xfer_cnt saturates at 16'hFFFF; after reset it reads 0.
